// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALUop codes, funct constants, issue FSM encoding and funct decoder
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_NOR = 3'b111;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
    } dec_t;

    // Unknown funct codes decode as illegal; 010 is never produced.
    function automatic dec_t decode_funct(input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        case (funct)
            FUNCT_ADD: d.op = ALU_ADD;
            FUNCT_SUB: d.op = ALU_SUB;
            FUNCT_XOR: d.op = ALU_XOR;
            FUNCT_AND: d.op = ALU_AND;
            FUNCT_OR:  d.op = ALU_OR;
            FUNCT_SLT: d.op = ALU_SLT;
            FUNCT_NOR: d.op = ALU_NOR;
            default:   d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational 32-bit ALU driven by the issue stage
module alu32
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        ALUop,
    output logic [DATA_W-1:0] Result
);

    always_comb begin
        Result = '0;
        case (ALUop)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_XOR: Result = A ^ B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_NOR: Result = ~(A | B);
            default: Result = '0;
        endcase
    end

endmodule

// File: rtl/regfile32.sv
// rtl/regfile32.sv - 32-entry register file, three async read ports, one sync write, R0 fixed at 0
module regfile32 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data  = (rs_addr  == 5'd0) ? '0 : regs[rs_addr];
    assign rt_data  = (rt_addr  == 5'd0) ? '0 : regs[rt_addr];
    assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// rtl/alu_issue_wb.sv - R-type issue, operand forwarding and writeback around alu32
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    output logic [CNT_W-1:0]  retire_cnt,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state;
    state_t            state_next;
    logic [5:0]        op;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [5:0]        funct;
    logic              unused_shamt;
    dec_t              dec;
    logic              legal;
    logic              accept;
    logic              e_valid;
    logic [4:0]        e_rd;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    assign dec    = decode_funct(funct);
    assign legal  = dec.legal && (op == 6'd0);
    assign accept = instr_valid && instr_ready;

    regfile32 #(.DATA_W(DATA_W)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (e_valid),
        .waddr    (e_rd),
        .wdata    (alu_result),
        .rs_addr  (rs),
        .rs_data  (rs_data),
        .rt_addr  (rt),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The retiring result is not in the register file yet, so bypass it to a dependent issue.
    always_comb begin
        a_next = rs_data;
        b_next = rt_data;
        if (e_valid && (e_rd != 5'd0) && (e_rd == rs)) a_next = alu_result;
        if (e_valid && (e_rd != 5'd0) && (e_rd == rt)) b_next = alu_result;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if ((state == ST_RUN) && accept && !legal) state_next = ST_HALT;
    end

    always_comb begin
        instr_ready = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid    <= 1'b0;
            e_rd       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= ALU_ADD;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            illegal    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            wb_valid <= e_valid;
            if (e_valid) begin
                wb_rd      <= e_rd;
                wb_data    <= alu_result;
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (accept && legal) begin
                e_valid <= 1'b1;
                e_rd    <= rd;
                alu_a   <= a_next;
                alu_b   <= b_next;
                alu_op  <= dec.op;
            end else begin
                e_valid <= 1'b0;
            end
            if (accept && !legal) illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// tb/tb_alu_issue_wb.sv - scoreboard bench for alu_issue_wb with the real alu32
module tb_alu_issue_wb;

    localparam int DW = 32;
    localparam int CW = 16;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_NOR = 6'h27;

    logic          clk;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_result;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          illegal;
    logic [CW-1:0] retire_cnt;
    logic [4:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    alu_issue_wb #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .retire_cnt  (retire_cnt),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    alu32 #(.DATA_W(DW)) u_alu (
        .A      (alu_a),
        .B      (alu_b),
        .ALUop  (alu_op),
        .Result (alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          model_cnt = 0;
    logic [31:0] model_regs [32];
    logic [4:0]  q_rd [$];
    logic [31:0] q_data [$];

    function automatic logic [31:0] model_alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_XOR:   return a ^ b;
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_NOR:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        @(negedge clk);
        chk(tag, dbg_data, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_cnt = 0;
    endtask

    task automatic issue(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        logic [31:0] r;
        instr       = mk(f, rs, rt, rd);
        instr_valid = 1'b1;
        r = model_alu(f, model_regs[rs], model_regs[rt]);
        @(posedge clk);
        #1;
        q_rd.push_back(rd);
        q_data.push_back(r);
        if (rd != 5'd0) model_regs[rd] = r;
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Builds any constant by shift-and-add using r31 == 1; the chain is fully back-to-back.
    task automatic load(input logic [4:0] rd, input logic [31:0] v);
        bit started;
        started = 1'b0;
        issue(F_ADD, 5'd0, 5'd0, rd);
        for (int i = 31; i >= 0; i--) begin
            if (started) issue(F_ADD, rd, rd, rd);
            if (v[i]) begin
                issue(F_ADD, rd, 5'd31, rd);
                started = 1'b1;
            end
        end
    endtask

    task automatic set_one();
        issue(F_NOR, 5'd0, 5'd0, 5'd31);
        issue(F_SUB, 5'd0, 5'd31, 5'd31);
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            checks++;
            assert (q_rd.size() > 0) else begin
                errors++;
                $error("FAIL wb_unexpected observed=rd%0d/%h expected=none", wb_rd, wb_data);
            end
            if (q_rd.size() > 0) begin
                logic [4:0]  erd;
                logic [31:0] edata;
                erd   = q_rd.pop_front();
                edata = q_data.pop_front();
                model_cnt++;
                checks++;
                assert ((wb_rd === erd) && (wb_data === edata)) else begin
                    errors++;
                    $error("FAIL wb_result observed=rd%0d/%h expected=rd%0d/%h", wb_rd, wb_data, erd, edata);
                end
            end
        end
    end

    initial begin
        model_clear();
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        dbg_addr    = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   {31'd0, instr_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid},   32'd0);
        chk("rst_illegal", {31'd0, illegal},     32'd0);
        chk("rst_cnt",     {16'd0, retire_cnt},  32'd0);
        chk("rst_alu_a",   alu_a,                32'd0);
        chk("rst_alu_b",   alu_b,                32'd0);
        chk("rst_alu_op",  {29'd0, alu_op},      32'd0);
        reset = 1'b0;

        issue(F_ADD, 5'd0, 5'd0, 5'd1);
        issue(F_ADD, 5'd1, 5'd1, 5'd2);
        idle(2);
        chk("preload_cnt", {16'd0, retire_cnt}, 32'd2);

        set_one();
        load(5'd1, 32'd16);
        load(5'd2, 32'd34);
        issue(F_ADD, 5'd1, 5'd2, 5'd3);
        issue(F_SUB, 5'd3, 5'd1, 5'd4);
        idle(2);
        chk_reg("r3_add", 5'd3, 32'd50);
        chk_reg("r4_sub", 5'd4, 32'd34);

        load(5'd5, 32'hABDF1234);
        load(5'd6, 32'h01259ECF);
        issue(F_XOR, 5'd5, 5'd6, 5'd8);
        issue(F_AND, 5'd5, 5'd6, 5'd9);
        issue(F_OR,  5'd5, 5'd6, 5'd10);
        issue(F_NOR, 5'd5, 5'd6, 5'd11);
        load(5'd12, 32'd100);
        load(5'd13, 32'd147);
        load(5'd14, 32'd47);
        issue(F_SLT, 5'd12, 5'd13, 5'd15);
        issue(F_SLT, 5'd12, 5'd14, 5'd16);
        idle(2);
        chk_reg("xor", 5'd8,  32'hAAFA8CFB);
        chk_reg("and", 5'd9,  32'h01051204);
        chk_reg("or",  5'd10, 32'hABFF9EFF);
        chk_reg("nor", 5'd11, 32'h54006100);
        chk_reg("slt_lt", 5'd15, 32'd1);
        chk_reg("slt_ge", 5'd16, 32'd0);
        idle(1);

        issue(F_ADD, 5'd1, 5'd2, 5'd0);
        idle(2);
        chk_reg("r0_stays_zero", 5'd0, 32'd0);
        chk("r0_cnt", {16'd0, retire_cnt}, model_cnt);
        idle(1);

        issue(F_ADD, 5'd1, 5'd2, 5'd17);
        instr       = mk(6'h00, 5'd1, 5'd2, 5'd18);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("halt_illegal", {31'd0, illegal},     32'd1);
        chk("halt_ready",   {31'd0, instr_ready}, 32'd0);
        instr = mk(F_ADD, 5'd1, 5'd2, 5'd18);
        repeat (3) @(posedge clk);
        #1;
        chk("halt_cnt_frozen", {16'd0, retire_cnt}, model_cnt);
        chk_reg("halt_prev_retired", 5'd17, 32'd50);
        chk_reg("halt_ignored", 5'd18, 32'd0);
        instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rerun_illegal", {31'd0, illegal},     32'd0);
        chk("rerun_ready",   {31'd0, instr_ready}, 32'd1);
        chk("rerun_cnt",     {16'd0, retire_cnt},  32'd0);
        chk("rerun_wb_data", wb_data,              32'd0);
        chk("rerun_alu_a",   alu_a,                32'd0);
        reset = 1'b0;
        model_clear();

        set_one();
        load(5'd1, 32'd16);
        idle(2);
        instr       = mk(F_ADD, 5'd1, 5'd31, 5'd7);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        idle(2);
        chk_reg("rst_inflight_r7", 5'd7, 32'd0);
        chk("rst_inflight_cnt", {16'd0, retire_cnt}, 32'd0);
        chk("queue_drained", q_rd.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
